// File: rtl/bus_uart_pkg.sv
// bus_uart shared definitions.
// Register offsets, STATUS bit indices, FSM states, bus byte swap.
package bus_uart_pkg;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;
  localparam logic [1:0] REG_RXDATA = 2'd3;

  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_TX_BUSY  = 2;
  localparam int ST_TX_OVF   = 3;
  localparam int ST_RX_VALID = 4;
  localparam int ST_RX_OVR   = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  function automatic logic [31:0] byteswap(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO for the UART transmit path.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o,
  output logic             overflow_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o     = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign rdata_o    = mem_q[rd_ptr_q];
  assign do_pop     = pop_i & ~empty_o;
  assign do_push    = push_i & (~full_o | do_pop);
  assign overflow_o = push_i & full_o & ~do_pop;

  // Occupancy follows accepted pushes and pops.
  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count state; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/bus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with TX FIFO on the core data bus.
// Optional receiver enabled by defining UART_RX_EN.
module bus_uart_tx
  import bus_uart_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic [3:0]  addr,
  input  logic [31:0] write_data,
  input  logic [3:0]  byte_mask,
  input  logic        write_en,
  output logic [31:0] read_data,
  output logic        txd
`ifdef UART_RX_EN
  ,
  input  logic        rxd
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]  reg_sel;
  logic        bus_wr, mask_all;
  logic [31:0] wd_sw;
  logic        tx_push, div_we, st_we, rx_pop;

  assign reg_sel  = addr[3:2];
  assign bus_wr   = sel & write_en;
  assign mask_all = (byte_mask == 4'b1111);
  assign wd_sw    = byteswap(write_data);
  assign tx_push  = bus_wr & (reg_sel == REG_TXDATA) & byte_mask[3];
  assign div_we   = bus_wr & (reg_sel == REG_DIV) & mask_all;
  assign st_we    = bus_wr & (reg_sel == REG_STATUS) & mask_all;
  assign rx_pop   = bus_wr & (reg_sel == REG_RXDATA) & mask_all;

  logic [7:0]    fifo_rdata;
  logic          fifo_pop, fifo_full, fifo_empty, fifo_ovf;
  logic [CW-1:0] fifo_count;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (tx_push),
    .wdata_i    (write_data[31:24]),
    .pop_i      (fifo_pop),
    .rdata_o    (fifo_rdata),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count),
    .overflow_o (fifo_ovf)
  );

  logic [15:0] div_q, div_d, eff_div;
  logic        ovf_q, ovf_d;
  logic [31:0] rdata_q, rdata_d;

  uart_state_t state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic [15:0] divcnt_q, divcnt_d;
  logic [15:0] period_q, period_d;
  logic        txd_q, txd_d;
  logic        bit_end;

  logic        rx_valid, rx_ovr;
  logic [7:0]  rx_data;

  assign eff_div = (div_q < 16'd2) ? 16'd2 : div_q;
  assign bit_end = (divcnt_q == period_q - 16'd1);

  // TX engine: next state, shifter and the txd level for the current state.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bitcnt_d = bitcnt_q;
    divcnt_d = divcnt_q;
    period_d = period_q;
    fifo_pop = 1'b0;
    txd_d    = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
          period_d = eff_div;
          divcnt_d = '0;
          bitcnt_d = '0;
          state_d  = START;
        end
      end
      START: begin
        txd_d    = 1'b0;
        divcnt_d = divcnt_q + 16'd1;
        if (bit_end) begin
          divcnt_d = '0;
          state_d  = DATA;
        end
      end
      DATA: begin
        txd_d    = shift_q[0];
        divcnt_d = divcnt_q + 16'd1;
        if (bit_end) begin
          divcnt_d = '0;
          shift_d  = {1'b0, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        divcnt_d = divcnt_q + 16'd1;
        if (bit_end) begin
          divcnt_d = '0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Register file updates, sticky overflow and registered read data.
  always_comb begin
    logic [31:0] status;
    div_d = div_q;
    if (div_we) div_d = wd_sw[15:0];
    ovf_d = (ovf_q & ~(st_we & wd_sw[ST_TX_OVF])) | fifo_ovf;
    status = '0;
    status[ST_TX_FULL]  = fifo_full;
    status[ST_TX_EMPTY] = fifo_empty;
    status[ST_TX_BUSY]  = (state_q != IDLE);
    status[ST_TX_OVF]   = ovf_q;
    status[ST_RX_VALID] = rx_valid;
    status[ST_RX_OVR]   = rx_ovr;
    rdata_d = '0;
    if (sel) begin
      case (reg_sel)
        REG_STATUS: rdata_d = byteswap(status);
        REG_DIV:    rdata_d = byteswap({16'h0, div_q});
        REG_RXDATA: rdata_d = byteswap({24'h0, rx_data});
        default:    rdata_d = '0;
      endcase
    end
  end

  // State registers; reset forces txd high at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      bitcnt_q <= '0;
      divcnt_q <= '0;
      period_q <= 16'd2;
      txd_q    <= 1'b1;
      div_q    <= DEFAULT_DIV;
      ovf_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bitcnt_q <= bitcnt_d;
      divcnt_q <= divcnt_d;
      period_q <= period_d;
      txd_q    <= txd_d;
      div_q    <= div_d;
      ovf_q    <= ovf_d;
      rdata_q  <= rdata_d;
    end
  end

  assign txd       = txd_q;
  assign read_data = rdata_q;

`ifdef UART_RX_EN
  logic [1:0]  rx_sync_q;
  logic        rx_prev_q, rx_in, rx_done;
  uart_state_t rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [15:0] rx_per_q, rx_per_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        rx_ovr_q, rx_ovr_d;
  logic        rx_load;

  assign rx_in = rx_sync_q[1];

  // RX engine: edge-triggered start, mid-bit sampling.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 16'd1;
    rx_per_d   = rx_per_q;
    rx_shift_d = rx_shift_q;
    rx_bit_d   = rx_bit_q;
    rx_done    = 1'b0;
    unique case (rx_state_q)
      IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q & ~rx_in) begin
          rx_per_d   = eff_div;
          rx_state_d = START;
        end
      end
      START: begin
        if (rx_cnt_q == (rx_per_q >> 1) - 16'd1) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_in ? IDLE : DATA;
        end
      end
      DATA: begin
        if (rx_cnt_q == rx_per_q - 16'd1) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_in, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = STOP;
        end
      end
      STOP: begin
        if (rx_cnt_q == rx_per_q - 16'd1) begin
          rx_cnt_d   = '0;
          rx_done    = rx_in;
          rx_state_d = IDLE;
        end
      end
      default: rx_state_d = IDLE;
    endcase
  end

  // Holding register: a pop in the same cycle frees it for a new byte.
  always_comb begin
    rx_load    = rx_done & (~rx_valid_q | rx_pop);
    rx_data_d  = rx_load ? rx_shift_q : rx_data_q;
    rx_valid_d = (rx_valid_q & ~rx_pop) | rx_load;
    rx_ovr_d   = (rx_ovr_q & ~(st_we & wd_sw[ST_RX_OVR]))
               | (rx_done & ~rx_load);
  end

  // RX synchroniser and state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_sync_q  <= 2'b11;
      rx_prev_q  <= 1'b1;
      rx_state_q <= IDLE;
      rx_cnt_q   <= '0;
      rx_per_q   <= 16'd2;
      rx_shift_q <= '0;
      rx_bit_q   <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_ovr_q   <= 1'b0;
    end else begin
      rx_sync_q  <= {rx_sync_q[0], rxd};
      rx_prev_q  <= rx_in;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_per_q   <= rx_per_d;
      rx_shift_q <= rx_shift_d;
      rx_bit_q   <= rx_bit_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_ovr_q   <= rx_ovr_d;
    end
  end

  assign rx_valid = rx_valid_q;
  assign rx_ovr   = rx_ovr_q;
  assign rx_data  = rx_data_q;
`else
  assign rx_valid = 1'b0;
  assign rx_ovr   = 1'b0;
  assign rx_data  = 8'h00;
`endif

  logic unused_w;
  assign unused_w = ^{addr[1:0], wd_sw, fifo_count, rx_pop};

endmodule

// File: tb/tb_bus_uart_tx.sv
// Self-checking bench for bus_uart_tx.
// Register table, exact waveform, overflow, reset and random frames.
module tb_bus_uart_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic [3:0]  addr;
  logic [31:0] write_data;
  logic [3:0]  byte_mask;
  logic        write_en;
  logic [31:0] read_data;
  logic        txd;
`ifdef UART_RX_EN
  logic        rxd = 1'b1;
`endif

  bus_uart_tx dut (
    .clk        (clk),
    .reset      (reset),
    .sel        (sel),
    .addr       (addr),
    .write_data (write_data),
    .byte_mask  (byte_mask),
    .write_en   (write_en),
    .read_data  (read_data),
    .txd        (txd)
`ifdef UART_RX_EN
    ,
    .rxd        (rxd)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    sel = 0; write_en = 0; addr = 0; write_data = 0; byte_mask = 0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d,
                    input logic [3:0] m);
    sel = 1; write_en = 1; addr = a; write_data = d; byte_mask = m;
    tick();
    idle();
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] v);
    sel = 1; write_en = 0; addr = a; byte_mask = 0;
    tick();
    v = read_data;
    idle();
  endtask

  function automatic logic [31:0] div_word(input int d);
    logic [15:0] v;
    v = 16'(d);
    return {v[7:0], v[15:8], 16'h0};
  endfunction

  // Serial decoder: frame sampled on the first cycle of every bit.
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int         mon_p = 4;
  bit         mon_en = 0;
  logic       prev_txd = 1'b1;
  logic [7:0] mb;

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && prev_txd === 1'b1 && txd === 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (mon_p) @(negedge clk);
          mb[i] = txd;
        end
        repeat (mon_p) @(negedge clk);
        check("stop bit", {31'h0, txd}, 32'h1);
        got_q.push_back(mb);
      end
      prev_txd = txd;
    end
  end

  task automatic wait_idle(input string nm);
    logic [31:0] st;
    int n;
    n = 0;
    do begin
      rd(4'h4, st);
      n++;
    end while (!(st[25] === 1'b1 && st[26] === 1'b0) && n < 3000);
    check({nm, " idle"}, {30'h0, st[26], st[25]}, 32'h1);
    repeat (4) tick();
  endtask

  task automatic cmp_queues(input string nm);
    check({nm, " count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s byte%0d", nm, i), {24'h0, got_q[i]},
            {24'h0, exp_q[i]});
    got_q.delete();
    exp_q.delete();
  endtask

  typedef struct {
    logic        s;
    logic        w;
    logic [3:0]  a;
    logic [31:0] d;
    logic [3:0]  m;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[15];

  initial begin
    logic [31:0] v;
    logic [7:0]  b;
    logic [7:0]  pat;
    int          lows, j, d, n;
    logic        e;

    idle();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    check("reset txd", {31'h0, txd}, 32'h1);
    check("reset rdata", read_data, 32'h0);

    tbl[0]  = '{1, 0, 4'h4, 32'h0,         4'h0, 1, 32'h0200_0000};
    tbl[1]  = '{1, 0, 4'h8, 32'h0,         4'h0, 1, 32'h6403_0000};
    tbl[2]  = '{1, 0, 4'h0, 32'h0,         4'h0, 1, 32'h0};
    tbl[3]  = '{1, 0, 4'hC, 32'h0,         4'h0, 1, 32'h0};
    tbl[4]  = '{1, 1, 4'h8, 32'h3412_0000, 4'hF, 0, 32'h0};
    tbl[5]  = '{1, 0, 4'h8, 32'h0,         4'h0, 1, 32'h3412_0000};
    tbl[6]  = '{1, 1, 4'h8, 32'hFFFF_0000, 4'h7, 0, 32'h0};
    tbl[7]  = '{1, 0, 4'h8, 32'h0,         4'h0, 1, 32'h3412_0000};
    tbl[8]  = '{1, 1, 4'h8, 32'hABCD_EF01, 4'hF, 0, 32'h0};
    tbl[9]  = '{1, 0, 4'hA, 32'h0,         4'h0, 1, 32'hABCD_0000};
    tbl[10] = '{1, 1, 4'h0, 32'h5500_0000, 4'h4, 0, 32'h0};
    tbl[11] = '{1, 0, 4'h4, 32'h0,         4'h0, 1, 32'h0200_0000};
    tbl[12] = '{1, 1, 4'h8, 32'h0400_0000, 4'hF, 0, 32'h0};
    tbl[13] = '{1, 0, 4'h8, 32'h0,         4'h0, 1, 32'h0400_0000};
    tbl[14] = '{0, 0, 4'h8, 32'h0,         4'h0, 1, 32'h0};

    for (int i = 0; i < 15; i++) begin
      sel = tbl[i].s; write_en = tbl[i].w; addr = tbl[i].a;
      write_data = tbl[i].d; byte_mask = tbl[i].m;
      tick();
      if (tbl[i].chk)
        check($sformatf("tbl%0d", i), read_data, tbl[i].exp);
    end
    idle();
    check("no push txd", {31'h0, txd}, 32'h1);

    // DIV=4, byte A5: exact txd level on each cycle after the write edge.
    pat = 8'hA5;
    wr(4'h0, 32'hA500_0000, 4'b1000);
    for (int k = 1; k <= 42; k++) begin
      tick();
      j = k - 2;
      if (k < 2)       e = 1'b1;
      else if (j < 4)  e = 1'b0;
      else if (j < 36) e = pat[(j - 4) / 4];
      else             e = 1'b1;
      check($sformatf("a5 wave k%0d", k), {31'h0, txd}, {31'h0, e});
    end
    wait_idle("a5");

    // DIV=2: 9 back-to-back writes fit, the 10th overflows.
    wr(4'h8, div_word(2), 4'hF);
    mon_p = 2;
    mon_en = 1;
    for (int i = 0; i < 9; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      wr(4'h0, {b, 24'h0}, 4'b1000);
    end
    rd(4'h4, v);
    check("full no ovf", v, 32'h0500_0000);
    wr(4'h0, 32'hEE00_0000, 4'b1000);
    rd(4'h4, v);
    check("ovf set", v, 32'h0D00_0000);
    wr(4'h4, 32'h0800_0000, 4'hF);
    rd(4'h4, v);
    check("ovf w1c", v, 32'h0500_0000);
    wait_idle("ovf");
    cmp_queues("ovf");
    mon_en = 0;

    // Reset in the middle of a data bit.
    wr(4'h8, div_word(4), 4'hF);
    wr(4'h0, 32'h0000_0000, 4'b1000);
    wr(4'h0, 32'h8100_0000, 4'b1000);
    repeat (7) tick();
    check("pre-reset low", {31'h0, txd}, 32'h0);
    #1 reset = 1'b1;
    #1 check("reset mid txd", {31'h0, txd}, 32'h1);
    tick();
    reset = 1'b0;
    rd(4'h4, v);
    check("post-reset st", v, 32'h0200_0000);
    rd(4'h8, v);
    check("post-reset div", v, 32'h6403_0000);
    lows = 0;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (txd !== 1'b1) lows++;
    end
    check("no residual", lows, 0);

    // Random dividers (including clamped values) and byte bursts.
    mon_en = 1;
    for (int it = 0; it < 4; it++) begin
      d = $urandom_range(0, 5);
      mon_p = (d < 2) ? 2 : d;
      wr(4'h8, div_word(d), 4'hF);
      n = $urandom_range(1, 9);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        exp_q.push_back(b);
        wr(4'h0, {b, 24'h0}, 4'b1000);
      end
      wait_idle($sformatf("rnd%0d", it));
      cmp_queues($sformatf("rnd%0d", it));
    end
    mon_en = 0;

`ifdef UART_RX_EN
    wr(4'h8, div_word(4), 4'hF);
    pat = 8'h3C;
    rxd = 0; repeat (4) tick();
    for (int i = 0; i < 8; i++) begin rxd = pat[i]; repeat (4) tick(); end
    rxd = 1; repeat (10) tick();
    rd(4'h4, v);
    check("rx valid", v, 32'h1200_0000);
    rd(4'hC, v);
    check("rx data", v, 32'h3C00_0000);
    pat = 8'h55;
    rxd = 0; repeat (4) tick();
    for (int i = 0; i < 8; i++) begin rxd = pat[i]; repeat (4) tick(); end
    rxd = 1; repeat (10) tick();
    rd(4'h4, v);
    check("rx overrun", v, 32'h3200_0000);
    wr(4'hC, 32'h0, 4'hF);
    rd(4'h4, v);
    check("rx pop", v, 32'h2200_0000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
